// File: rtl/serial_flit_receiver_if.sv
// Serial flit link plus FIFO consumer port and status counters.
// The receiver sits on the slave side.
interface serial_flit_receiver_if #(
  parameter int FLIT_WIDTH = 8
);
  logic                  rx_data;
  logic                  rx_busy;
  logic [FLIT_WIDTH-1:0] flit_out;
  logic                  flit_valid;
  logic                  flit_ready;
  logic [15:0]           flit_count;
  logic [7:0]            misroute_count;
  logic                  overrun;

  modport master (
    output rx_data,
    output flit_ready,
    input  rx_busy,
    input  flit_out,
    input  flit_valid,
    input  flit_count,
    input  misroute_count,
    input  overrun
  );

  modport slave (
    input  rx_data,
    input  flit_ready,
    output rx_busy,
    output flit_out,
    output flit_valid,
    output flit_count,
    output misroute_count,
    output overrun
  );
endinterface

// File: rtl/serial_flit_receiver.sv
// Deserialises start-bit framed flits (LSB first) into a fall-through
// FIFO, with backpressure, destination check and traffic counters.
module serial_flit_receiver #(
  parameter int ID         = 0,
  parameter int FLIT_WIDTH = 8,
  parameter int DEST_BITS  = 4,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  serial_flit_receiver_if.slave  rx
);
  localparam int CW = (FLIT_WIDTH > 1) ? $clog2(FLIT_WIDTH) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(FLIT_WIDTH - 1);
  localparam logic [DEST_BITS-1:0] MY_ID = DEST_BITS'(ID);

  typedef enum logic {
    IDLE,
    RECV
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FLIT_WIDTH-1:0] sh_q, sh_d;
  logic [FLIT_WIDTH-1:0] wr_flit;
  logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         rd_q, wr_q;
  logic [AW:0]           occ_q, occ_d;
  logic [15:0]           fcnt_q, fcnt_d;
  logic [7:0]            mis_q, mis_d;
  logic                  ovr_q, ovr_d;
  logic                  recv, busy, push, pop;

  always_comb begin
    recv    = (state_q == RECV);
    busy    = reset |
              (({1'b0, occ_q} + (AW+2)'(recv)) >= (AW+2)'(DEPTH));
    pop     = (occ_q != '0) && rx.flit_ready;
    wr_flit = sh_q;
    wr_flit[cnt_q] = rx.rx_data;
    push    = recv && (cnt_q == LAST);

    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (rx.rx_data) begin
          if (busy) begin
            ovr_d = 1'b1;
          end else begin
            state_d = RECV;
            cnt_d   = '0;
          end
        end
      end
      RECV: begin
        sh_d  = wr_flit;
        cnt_d = cnt_q + 1'b1;
        if (push) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    endcase

    occ_d = occ_q;
    if (push && !pop) occ_d = occ_q + 1'b1;
    if (pop && !push) occ_d = occ_q - 1'b1;

    fcnt_d = fcnt_q;
    mis_d  = mis_q;
    if (push) begin
      fcnt_d = fcnt_q + 16'd1;
      // Misrouted flits are still stored; only counted.
      if (wr_flit[DEST_BITS-1:0] != MY_ID && mis_q != 8'hFF)
        mis_d = mis_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      occ_q   <= '0;
      fcnt_q  <= '0;
      mis_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      occ_q   <= occ_d;
      fcnt_q  <= fcnt_d;
      mis_q   <= mis_d;
      ovr_q   <= ovr_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wr_flit;
  end

  assign rx.rx_busy        = busy;
  assign rx.flit_out       = mem_q[rd_q];
  assign rx.flit_valid     = (occ_q != '0);
  assign rx.flit_count     = fcnt_q;
  assign rx.misroute_count = mis_q;
  assign rx.overrun        = ovr_q;
endmodule

// File: tb/tb_serial_flit_receiver.sv
// Bench for serial_flit_receiver: vector table, corner sequences,
// and a randomized run against a queue-based reference model.
module tb_serial_flit_receiver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_flit_receiver_if #(.FLIT_WIDTH(8)) bus ();

  serial_flit_receiver #(
    .ID(4), .FLIT_WIDTH(8), .DEST_BITS(4), .DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(bus)
  );

  typedef struct {
    logic [7:0] d;
    logic [7:0] out;
    int         cnt;
    int         mis;
  } vec_t;

  vec_t tbl[5];
  logic [7:0] seq[4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    bus.rx_data = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.rx_data = d[i];
      tick();
    end
    bus.rx_data = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(bus.rx_busy), 32'd1);
    chk({tag, "_valid"}, 32'(bus.flit_valid), 32'd0);
    chk({tag, "_count"}, 32'(bus.flit_count), 32'd0);
    chk({tag, "_mis"}, 32'(bus.misroute_count), 32'd0);
    chk({tag, "_ovr"}, 32'(bus.overrun), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.rx_data = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Reference model state
  logic [7:0] mq[$];
  bit         m_recv;
  int         m_idx;
  logic [7:0] m_part;
  int         m_cnt;
  int         m_mis;
  bit         m_ovr;

  initial begin
    tbl[0] = '{8'hA4, 8'hA4, 1, 0};
    tbl[1] = '{8'h13, 8'h13, 2, 1};
    tbl[2] = '{8'h54, 8'h54, 3, 1};
    tbl[3] = '{8'hFF, 8'hFF, 4, 2};
    tbl[4] = '{8'h04, 8'h04, 5, 2};
    seq[0] = 8'h14;
    seq[1] = 8'h27;
    seq[2] = 8'hC4;
    seq[3] = 8'h39;

    bus.rx_data = 1'b0;
    bus.flit_ready = 1'b1;
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    #1;
    chk("rel_busy", 32'(bus.rx_busy), 32'd0);

    // Table: ready held high, each flit visible exactly one cycle
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].d);
      chk("tbl_valid", 32'(bus.flit_valid), 32'd1);
      chk("tbl_out", 32'(bus.flit_out), 32'(tbl[i].out));
      chk("tbl_count", 32'(bus.flit_count), 32'(tbl[i].cnt));
      chk("tbl_mis", 32'(bus.misroute_count), 32'(tbl[i].mis));
      tick();
      chk("tbl_valid_drop", 32'(bus.flit_valid), 32'd0);
    end

    // Fill the FIFO, then overrun, then a single pop
    do_reset();
    bus.flit_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(seq[i]);
    chk("fill3_busy", 32'(bus.rx_busy), 32'd0);
    bus.rx_data = 1'b1;
    tick();
    chk("fill4_busy", 32'(bus.rx_busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      bus.rx_data = seq[3][i];
      tick();
    end
    bus.rx_data = 1'b0;
    chk("full_busy", 32'(bus.rx_busy), 32'd1);
    chk("full_count", 32'(bus.flit_count), 32'd4);
    bus.rx_data = 1'b1;
    tick();
    bus.rx_data = 1'b0;
    chk("ovr_flag", 32'(bus.overrun), 32'd1);
    chk("ovr_count", 32'(bus.flit_count), 32'd4);
    chk("ovr_head", 32'(bus.flit_out), 32'(seq[0]));
    chk("ovr_busy", 32'(bus.rx_busy), 32'd1);
    tick();
    chk("ovr_idle", 32'(bus.rx_busy), 32'd1);
    bus.flit_ready = 1'b1;
    tick();
    bus.flit_ready = 1'b0;
    chk("pop_busy", 32'(bus.rx_busy), 32'd0);
    chk("pop_head", 32'(bus.flit_out), 32'(seq[1]));
    send(8'h5A);
    chk("refill_count", 32'(bus.flit_count), 32'd5);
    chk("refill_busy", 32'(bus.rx_busy), 32'd1);
    bus.flit_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk("drain_valid", 32'(bus.flit_valid), 32'd1);
      chk("drain_out", 32'(bus.flit_out), 32'(seq[i]));
      tick();
    end
    chk("drain_valid", 32'(bus.flit_valid), 32'd1);
    chk("drain_out", 32'(bus.flit_out), 32'h5A);
    tick();
    chk("drain_empty", 32'(bus.flit_valid), 32'd0);
    chk("drain_ovr", 32'(bus.overrun), 32'd1);

    // Reset in the middle of a flit
    do_reset();
    bus.flit_ready = 1'b1;
    bus.rx_data = 1'b1;
    tick();
    bus.rx_data = 1'b1;
    tick();
    bus.rx_data = 1'b0;
    tick();
    bus.rx_data = 1'b1;
    tick();
    reset = 1'b1;
    bus.rx_data = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_rel_busy", 32'(bus.rx_busy), 32'd0);
    send(8'h54);
    chk("midrst_valid", 32'(bus.flit_valid), 32'd1);
    chk("midrst_out", 32'(bus.flit_out), 32'h54);
    chk("midrst_count", 32'(bus.flit_count), 32'd1);
    chk("midrst_mis", 32'(bus.misroute_count), 32'd0);

    // Misroute counter saturation
    do_reset();
    bus.flit_ready = 1'b1;
    for (int i = 0; i < 260; i++) send(8'h0F);
    chk("sat_mis", 32'(bus.misroute_count), 32'd255);
    chk("sat_count", 32'(bus.flit_count), 32'd260);

    // Randomized traffic against the queue model
    do_reset();
    mq.delete();
    m_recv = 0;
    m_idx = 0;
    m_part = '0;
    m_cnt = 0;
    m_mis = 0;
    m_ovr = 0;
    for (int c = 0; c < 3000; c++) begin
      bit m_busy;
      bit rx;
      bit rdy;
      bit do_pop;
      m_busy = (mq.size() + int'(m_recv)) >= 4;
      chk("rnd_busy", 32'(bus.rx_busy), 32'(m_busy));
      chk("rnd_valid", 32'(bus.flit_valid), 32'(mq.size() > 0));
      if (mq.size() > 0)
        chk("rnd_out", 32'(bus.flit_out), 32'(mq[0]));
      chk("rnd_count", 32'(bus.flit_count), 32'(m_cnt));
      chk("rnd_mis", 32'(bus.misroute_count), 32'(m_mis));
      chk("rnd_ovr", 32'(bus.overrun), 32'(m_ovr));
      rx = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 9) < 4);
      bus.rx_data = rx;
      bus.flit_ready = rdy;
      tick();
      do_pop = (mq.size() > 0) && rdy;
      if (do_pop) void'(mq.pop_front());
      if (m_recv) begin
        m_part[m_idx] = rx;
        if (m_idx == 7) begin
          mq.push_back(m_part);
          m_cnt = (m_cnt + 1) % 65536;
          if (m_part[3:0] != 4'd4 && m_mis < 255) m_mis++;
          m_recv = 0;
        end else begin
          m_idx++;
        end
      end else if (rx) begin
        if (m_busy) begin
          m_ovr = 1;
        end else begin
          m_recv = 1;
          m_idx = 0;
          m_part = '0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_flit_receiver.md
SERIAL_FLIT_RECEIVER -- requirements
Module: serial_flit_receiver

Interface
REQ-001 The block SHALL have parameter ID, default 0: node index; the expected destination of every received flit.
REQ-002 The block SHALL have parameter FLIT_WIDTH, default 8: data bits per flit.
REQ-003 The block SHALL have parameter DEST_BITS, default 4: width of the destination field, flit bits [DEST_BITS-1:0].
REQ-004 The block SHALL have parameter DEPTH, default 4: FIFO capacity in flits, power of two, minimum 2.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port rx_data, input, 1 bit: serial line from the router tx_data port.
REQ-008 The block SHALL have port rx_busy, output, 1 bit: backpressure to the router tx_busy port.
REQ-009 The block SHALL have port flit_out, output, FLIT_WIDTH bits: FIFO head flit.
REQ-010 The block SHALL have port flit_valid, output, 1 bit: flit_out holds a valid flit.
REQ-011 The block SHALL have port flit_ready, input, 1 bit: consumer accepts flit_out.
REQ-012 The block SHALL have port flit_count, output, 16 bits: flits written to the FIFO.
REQ-013 The block SHALL have port misroute_count, output, 8 bits: flits whose destination field is not ID.
REQ-014 The block SHALL have port overrun, output, 1 bit: sticky flag, start bit received while busy.

Function
REQ-015 Line protocol SHALL be: idle low; one start bit '1'; then FLIT_WIDTH data bits, one per cycle, LSB first; the next start bit may follow directly on the cycle after the last data bit.
REQ-016 FSM SHALL have two states: IDLE and RECV. IDLE->RECV on rx_data=1 with rx_busy=0. RECV->IDLE on the edge sampling data bit FLIT_WIDTH-1. No other transitions apart from reset.
REQ-017 In RECV, a bit counter of width clog2(FLIT_WIDTH) SHALL count 0..FLIT_WIDTH-1. Bit k SHALL be shifted into position k of a shift register.
REQ-018 The assembled flit SHALL be written to the FIFO on the edge that samples its last data bit. flit_valid SHALL be high after that edge when the FIFO was empty.
REQ-019 The FIFO SHALL be first-word fall-through. flit_out SHALL equal the head entry when flit_valid=1 and SHALL be don't-care otherwise.
REQ-020 A pop SHALL occur on an edge where flit_valid=1 and flit_ready=1. A simultaneous pop and write SHALL leave occupancy unchanged.
REQ-021 rx_busy SHALL be combinational from registers: 1 when occupancy + (state==RECV) >= DEPTH, else 0. Result: a flit being received always has a free slot.
REQ-022 rx_data=1 in IDLE while rx_busy=1 SHALL be ignored: state stays IDLE and overrun is set to 1 until reset.
REQ-023 flit_count SHALL increment by 1 per FIFO write and wrap from 65535 to 0.
REQ-024 misroute_count SHALL increment per FIFO write whose bits [DEST_BITS-1:0] != ID[DEST_BITS-1:0], and saturate at 255.
REQ-025 Misrouted flits SHALL still be written to the FIFO.

Reset
REQ-026 While reset is high, all of the following SHALL hold: state=IDLE; bit counter 0; shift register 0; FIFO empty; flit_valid=0; flit_count=0; misroute_count=0; overrun=0; rx_busy=1 (forced).
REQ-027 After reset deasserts, rx_busy SHALL follow REQ-021 and read 0 on the first cycle.
REQ-028 Reset asserted mid-flit SHALL discard the partial flit immediately without any FIFO write. The first start bit after release SHALL begin a fresh flit.

Verification
REQ-029 Configuration ID=4, FLIT_WIDTH=8, DEPTH=4, flit_ready=1: send start bit then 0xA4 (bits 0,0,1,0,0,1,0,1). Required: flit_valid=1 for exactly one cycle after the last bit edge, with flit_out=0xA4, flit_count=1, misroute_count=0.
REQ-030 Send flit 0x13 (destination 3). Required: misroute_count=1, and flit_out=0x13 is delivered.
REQ-031 flit_ready=0, send 4 flits back-to-back. Required: rx_busy=1 from the cycle after the 4th start bit. Then drive a 5th start bit. Required: overrun=1, flit_count=4, FIFO unchanged.
REQ-032 Then flit_ready=1 for one cycle. Required: first flit popped, rx_busy=0 on the next cycle, and a following flit is accepted, giving flit_count=5.
REQ-033 Assert reset after 3 data bits of a flit. Required: all outputs at REQ-026 values. Then send 0x54. Required: flit_out=0x54 and flit_count=1.
